// File: rtl/div_datapath.sv
// Iterative restoring unsigned divider datapath, stepped one quotient bit per
// cycle by the divider control sequencer and publishing results on its DONE code.
module div_datapath #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CW        = 6,
    parameter int unsigned CODE_ITER = 27,
    parameter int unsigned CODE_DONE = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [CW-1:0]    ctrl,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_zero,
    output logic             seq_err
);

    localparam int unsigned SW = $clog2(WIDTH + 1);
    localparam logic [SW-1:0] STEP_MAX = SW'(WIDTH);
    localparam logic [CW-1:0] C_ITER   = CW'(CODE_ITER);
    localparam logic [CW-1:0] C_DONE   = CW'(CODE_DONE);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] rem_acc, quo_acc, dvs, dvd_cap;
    logic [SW-1:0]    step;
    logic [WIDTH-1:0] rem_shift, quo_shift;
    logic [WIDTH:0]   trial;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FIN: if (start) state_nxt = RUN;
            RUN: begin
                if (start)
                    state_nxt = RUN;
                else if (ctrl == C_DONE && step == STEP_MAX)
                    state_nxt = FIN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The bit shifted out of rem_acc is dropped; trial is taken on the shifted value only.
    always_comb begin
        rem_shift = {rem_acc[WIDTH-2:0], quo_acc[WIDTH-1]};
        quo_shift = {quo_acc[WIDTH-2:0], 1'b0};
        trial     = {1'b0, rem_shift} - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_acc   <= '0;
            quo_acc   <= '0;
            dvs       <= '0;
            dvd_cap   <= '0;
            step      <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            div_zero  <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            if (start) begin
                rem_acc  <= '0;
                quo_acc  <= dividend;
                dvs      <= divisor;
                dvd_cap  <= dividend;
                step     <= '0;
                done     <= 1'b0;
                seq_err  <= 1'b0;
                div_zero <= 1'b0;
            end else if (state == RUN) begin
                if (ctrl == C_ITER && step < STEP_MAX) begin
                    if (!trial[WIDTH]) begin
                        rem_acc <= trial[WIDTH-1:0];
                        quo_acc <= {quo_shift[WIDTH-1:1], 1'b1};
                    end else begin
                        rem_acc <= rem_shift;
                        quo_acc <= quo_shift;
                    end
                    step <= step + 1'b1;
                end else if (ctrl == C_DONE) begin
                    if (step == STEP_MAX) begin
                        done <= 1'b1;
                        if (dvs == '0) begin
                            quotient  <= '1;
                            remainder <= dvd_cap;
                            div_zero  <= 1'b1;
                        end else begin
                            quotient  <= quo_acc;
                            remainder <= rem_acc;
                        end
                    end else begin
                        seq_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_div_datapath.sv
// Directed bench for div_datapath: hand-computed quotient/remainder and flag checks.
module tb_div_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend, divisor;
    logic [5:0]  ctrl;
    logic [31:0] quotient, remainder;
    logic        done, busy, div_zero, seq_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    div_datapath #(
        .WIDTH(32),
        .CW(6),
        .CODE_ITER(27),
        .CODE_DONE(63)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .ctrl(ctrl),
        .quotient(quotient),
        .remainder(remainder),
        .done(done),
        .busy(busy),
        .div_zero(div_zero),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs applied here take effect at the next rising edge; sampling is 1ns after it.
    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; dividend = a; divisor = b;
        tick();
        start = 1'b0; dividend = '0; divisor = '0;
    endtask

    task automatic iter(input int unsigned n);
        ctrl = 6'd27;
        tick(n);
        ctrl = 6'd0;
    endtask

    task automatic done_code();
        ctrl = 6'd63;
        tick();
        ctrl = 6'd0;
    endtask

    task automatic full_div(input logic [31:0] a, input logic [31:0] b);
        do_start(a, b);
        iter(32);
        done_code();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0; ctrl = '0;
        tick(2);
        rst_n = 1'b1;
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        check("rst_seq", 32'(seq_err), 32'd0);

        // 100 / 7
        do_start(32'd100, 32'd7);
        check("a_busy", 32'(busy), 32'd1);
        iter(32);
        check("a_notdone", 32'(done), 32'd0);
        done_code();
        check("a_q", quotient, 32'd14);
        check("a_r", remainder, 32'd2);
        check("a_done", 32'(done), 32'd1);
        check("a_busy0", 32'(busy), 32'd0);
        check("a_seq", 32'(seq_err), 32'd0);
        iter(3);
        check("a_fin_hold_q", quotient, 32'd14);
        check("a_fin_hold_done", 32'(done), 32'd1);

        // back-to-back 0xFFFFFFFF/1 then 5/9
        full_div(32'hFFFF_FFFF, 32'd1);
        check("b_q", quotient, 32'hFFFF_FFFF);
        check("b_r", remainder, 32'd0);
        do_start(32'd5, 32'd9);
        check("c_done_clr", 32'(done), 32'd0);
        check("c_q_kept", quotient, 32'hFFFF_FFFF);
        iter(32);
        done_code();
        check("c_q", quotient, 32'd0);
        check("c_r", remainder, 32'd5);

        // 1234 / 0
        full_div(32'd1234, 32'd0);
        check("z_q", quotient, 32'hFFFF_FFFF);
        check("z_r", remainder, 32'd1234);
        check("z_dz", 32'(div_zero), 32'd1);
        check("z_done", 32'(done), 32'd1);

        // early DONE on 50 / 3
        do_start(32'd50, 32'd3);
        check("e_dz_clr", 32'(div_zero), 32'd0);
        iter(10);
        done_code();
        check("e_seq", 32'(seq_err), 32'd1);
        check("e_done", 32'(done), 32'd0);
        check("e_busy", 32'(busy), 32'd1);
        check("e_q_kept", quotient, 32'hFFFF_FFFF);
        iter(22);
        done_code();
        check("e_q", quotient, 32'd16);
        check("e_r", remainder, 32'd2);
        check("e_seq_sticky", 32'(seq_err), 32'd1);

        // overrun on 77 / 8
        do_start(32'd77, 32'd8);
        check("o_seq_clr", 32'(seq_err), 32'd0);
        iter(40);
        done_code();
        check("o_q", quotient, 32'd9);
        check("o_r", remainder, 32'd5);
        check("o_seq", 32'(seq_err), 32'd0);

        // restart at step 12 with ITER on the same edge; unrelated codes hold
        do_start(32'd1000, 32'd3);
        iter(12);
        start = 1'b1; dividend = 32'd9; divisor = 32'd2; ctrl = 6'd27;
        tick();
        start = 1'b0; dividend = '0; divisor = '0; ctrl = '0;
        iter(16);
        ctrl = 6'd5;
        tick(3);
        iter(16);
        check("s_notdone", 32'(done), 32'd0);
        done_code();
        check("s_q", quotient, 32'd4);
        check("s_r", remainder, 32'd1);
        check("s_done", 32'(done), 32'd1);

        // reset mid-RUN
        do_start(32'd100, 32'd7);
        iter(20);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("m_q", quotient, 32'd0);
        check("m_r", remainder, 32'd0);
        check("m_done", 32'(done), 32'd0);
        check("m_busy", 32'(busy), 32'd0);
        done_code();
        iter(2);
        done_code();
        check("m_done_after", 32'(done), 32'd0);
        check("m_busy_after", 32'(busy), 32'd0);
        check("m_seq_after", 32'(seq_err), 32'd0);
        check("m_q_after", quotient, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_datapath.md
Name: div_datapath

Overview:
- Iterative restoring unsigned divider datapath; the responder to the divider control sequencer.
- Operands are captured on a start pulse.
- Advances exactly one quotient bit per cycle while the 6-bit control code equals ITERATE.
- Publishes quotient/remainder when the code equals DONE.
- Sits between the EX-stage operand latches and the HI/LO result registers of the pipeline.

Parameters:
WIDTH, 32, operand/result width in bits
CW, 6, control code width
CODE_ITER, 27, control code requesting one division step
CODE_DONE, 63, control code requesting result publication

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  single-cycle pulse: capture dividend/divisor, begin new division
dividend  input  WIDTH  unsigned dividend, sampled only when start=1
divisor  input  WIDTH  unsigned divisor, sampled only when start=1
ctrl  input  CW  control code from the divider sequencer
quotient  output  WIDTH  registered quotient, valid when done=1
remainder  output  WIDTH  registered remainder, valid when done=1
done  output  1  level; result valid, held until next start or reset
busy  output  1  high in RUN state
div_zero  output  1  divisor was zero for current/last result
seq_err  output  1  sticky; CODE_DONE arrived before WIDTH steps; cleared by start/reset

Behaviour:
- Reset: rst_n=0 at a clk edge forces state IDLE. All outputs go to 0; internal rem/quo/step cleared. Reset wins over every other input, including mid-RUN.
- States: IDLE, RUN, FIN.
- IDLE/FIN + start=1 -> RUN. On the same edge:
  - load rem_acc=0, quo_acc=dividend, dvs=divisor, step=0.
  - clear done, seq_err, div_zero.
- RUN + start=1 -> restart with new operands; in-flight division is discarded. start has priority over ctrl in any state.
- RUN + ctrl==CODE_ITER + step<WIDTH: one restoring step:
  - shift {rem_acc,quo_acc} left 1.
  - trial = {1'b0,rem_shifted} - {1'b0,dvs}, WIDTH+1 bits.
  - If trial MSB==0: rem_acc=trial[WIDTH-1:0], quo_acc[0]=1; else rem_acc=rem_shifted, quo_acc[0]=0.
  - step++.
- RUN + ctrl==CODE_ITER + step==WIDTH: no change. step saturates, no error.
- RUN + ctrl==CODE_DONE + step==WIDTH -> FIN:
  - quotient=quo_acc, remainder=rem_acc, done=1.
  - If dvs==0: quotient=all ones, remainder=captured dividend, div_zero=1.
- RUN + ctrl==CODE_DONE + step<WIDTH: seq_err=1, state stays RUN, accumulators untouched, outputs unchanged.
- Any other ctrl value: hold; no state change.
- IDLE/FIN ignore all ctrl codes. Results hold in FIN indefinitely.
- busy = (state==RUN), registered.
- Latency: start edge + WIDTH ITERATE cycles + 1 DONE cycle. done rises on the edge sampling CODE_DONE, and is visible the following cycle. Minimum WIDTH+2 cycles from start to done visible.
- Divide-by-zero: steps still execute; the zero override applies only at publication.
- quotient/remainder change only on publication or reset. A start does not clear them, only done.

Test Plan:
- 100/7: start, 32×ctrl=27, ctrl=63 -> quotient=14, remainder=2, done=1, busy=0, seq_err=0.
- 0xFFFFFFFF/1 then 5/9 back-to-back:
  - first result: quotient=0xFFFFFFFF, remainder=0.
  - second start clears done; second result: quotient=0, remainder=5.
- 1234/0, full sequence -> quotient=0xFFFFFFFF, remainder=1234, div_zero=1, done=1.
- Early DONE: start 50/3, 10×ITER, ctrl=63:
  - seq_err=1, done=0, busy=1.
  - then 22×ITER + ctrl=63 -> quotient=16, remainder=2, seq_err still 1.
- Overrun plus restart:
  - 40×ITER then DONE on 77/8 -> quotient=9, remainder=5.
  - start 9/2 asserted at step 12 with ctrl=27 same cycle -> restart wins; full sequence yields quotient=4, remainder=1.
- Reset mid-RUN: rst_n=0 at step 20 -> next cycle all outputs 0, state IDLE; ctrl=63 afterwards has no effect.
